// File: rtl/lsu_axi_master.sv
// LSU-side AXI4 master: one single-beat read or write per request.
// Sequences AR/R or AW/W/B, then hands completion to writeback.
module lsu_axi_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int ID_VAL = 0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                req_write_i,
  input  logic [ADDR_W-1:0]   req_addr_i,
  input  logic [2:0]          req_size_i,
  input  logic [DATA_W-1:0]   req_wdata_i,
  input  logic [DATA_W/8-1:0] req_wstrb_i,
  output logic                awvalid_o,
  input  logic                awready_i,
  output logic [ADDR_W-1:0]   awaddr_o,
  output logic [3:0]          awid_o,
  output logic [7:0]          awlen_o,
  output logic [2:0]          awsize_o,
  output logic [1:0]          awburst_o,
  output logic                wvalid_o,
  input  logic                wready_i,
  output logic [DATA_W-1:0]   wdata_o,
  output logic [DATA_W/8-1:0] wstrb_o,
  output logic                wlast_o,
  input  logic                bvalid_i,
  output logic                bready_o,
  input  logic [1:0]          bresp_i,
  output logic                arvalid_o,
  input  logic                arready_i,
  output logic [ADDR_W-1:0]   araddr_o,
  output logic [3:0]          arid_o,
  output logic [7:0]          arlen_o,
  output logic [2:0]          arsize_o,
  output logic [1:0]          arburst_o,
  input  logic                rvalid_i,
  output logic                rready_o,
  input  logic [DATA_W-1:0]   rdata_i,
  input  logic [1:0]          rresp_i,
  input  logic                rlast_i,
  output logic [DATA_W-1:0]   rdata_o,
  output logic                rdata_we_o,
  output logic                done_valid_o,
  input  logic                done_ready_i,
  output logic                err_o
);

  typedef enum logic [2:0] {
    IDLE, RADDR, RDATA, WRITE, WRESP, DONE
  } state_e;

  state_e                state_q;
  logic                  req_ready_q;
  logic                  awvalid_q;
  logic                  wvalid_q;
  logic                  bready_q;
  logic                  arvalid_q;
  logic                  rready_q;
  logic                  done_valid_q;
  logic                  aw_done_q;
  logic                  w_done_q;
  logic                  err_q;
  logic                  rdata_we_q;
  logic [DATA_W-1:0]     rdata_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [2:0]            size_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [DATA_W/8-1:0]   wstrb_q;

  logic aw_hs;
  logic w_hs;
  logic aw_fin;
  logic w_fin;
  logic unused_rlast;

  // Single-beat reads: the last flag carries no extra information.
  assign unused_rlast = rlast_i;

  // Write-channel handshakes; a finished channel stays finished.
  always_comb begin
    aw_hs  = awvalid_q & awready_i;
    w_hs   = wvalid_q & wready_i;
    aw_fin = aw_done_q | aw_hs;
    w_fin  = w_done_q | w_hs;
  end

  // Transaction sequencer with registered handshake outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b1;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      done_valid_q <= 1'b0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      err_q        <= 1'b0;
      rdata_we_q   <= 1'b0;
      rdata_q      <= '0;
      addr_q       <= '0;
      size_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
    end else begin
      rdata_we_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req_valid_i && req_ready_q) begin
            addr_q      <= req_addr_i;
            size_q      <= req_size_i;
            wdata_q     <= req_wdata_i;
            wstrb_q     <= req_wstrb_i;
            req_ready_q <= 1'b0;
            if (req_write_i) begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              aw_done_q <= 1'b0;
              w_done_q  <= 1'b0;
              state_q   <= WRITE;
            end else begin
              arvalid_q <= 1'b1;
              state_q   <= RADDR;
            end
          end
        end
        RADDR: begin
          if (arready_i) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= RDATA;
          end
        end
        RDATA: begin
          if (rvalid_i) begin
            rdata_q      <= rdata_i;
            rdata_we_q   <= 1'b1;
            err_q        <= (rresp_i != 2'b00);
            rready_q     <= 1'b0;
            done_valid_q <= 1'b1;
            state_q      <= DONE;
          end
        end
        WRITE: begin
          if (aw_hs) awvalid_q <= 1'b0;
          if (w_hs)  wvalid_q  <= 1'b0;
          aw_done_q <= aw_fin;
          w_done_q  <= w_fin;
          if (aw_fin && w_fin) begin
            bready_q <= 1'b1;
            state_q  <= WRESP;
          end
        end
        WRESP: begin
          if (bvalid_i) begin
            err_q        <= (bresp_i != 2'b00);
            bready_q     <= 1'b0;
            done_valid_q <= 1'b1;
            state_q      <= DONE;
          end
        end
        DONE: begin
          if (done_ready_i) begin
            done_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready_o  = req_ready_q;
  assign awvalid_o    = awvalid_q;
  assign awaddr_o     = addr_q;
  assign awid_o       = 4'(ID_VAL);
  assign awlen_o      = 8'd0;
  assign awsize_o     = size_q;
  assign awburst_o    = 2'b01;
  assign wvalid_o     = wvalid_q;
  assign wdata_o      = wdata_q;
  assign wstrb_o      = wstrb_q;
  assign wlast_o      = 1'b1;
  assign bready_o     = bready_q;
  assign arvalid_o    = arvalid_q;
  assign araddr_o     = addr_q;
  assign arid_o       = 4'(ID_VAL);
  assign arlen_o      = 8'd0;
  assign arsize_o     = size_q;
  assign arburst_o    = 2'b01;
  assign rready_o     = rready_q;
  assign rdata_o      = rdata_q;
  assign rdata_we_o   = rdata_we_q;
  assign done_valid_o = done_valid_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_lsu_axi_master.sv
// Directed bench for lsu_axi_master.
// Linear stimulus; immediate assertions at each check.
module tb_lsu_axi_master;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid_i, req_ready_o, req_write_i;
  logic [31:0] req_addr_i;
  logic [2:0]  req_size_i;
  logic [63:0] req_wdata_i;
  logic [7:0]  req_wstrb_i;
  logic        awvalid_o, awready_i;
  logic [31:0] awaddr_o;
  logic [3:0]  awid_o;
  logic [7:0]  awlen_o;
  logic [2:0]  awsize_o;
  logic [1:0]  awburst_o;
  logic        wvalid_o, wready_i;
  logic [63:0] wdata_o;
  logic [7:0]  wstrb_o;
  logic        wlast_o;
  logic        bvalid_i, bready_o;
  logic [1:0]  bresp_i;
  logic        arvalid_o, arready_i;
  logic [31:0] araddr_o;
  logic [3:0]  arid_o;
  logic [7:0]  arlen_o;
  logic [2:0]  arsize_o;
  logic [1:0]  arburst_o;
  logic        rvalid_i, rready_o;
  logic [63:0] rdata_i;
  logic [1:0]  rresp_i;
  logic        rlast_i;
  logic [63:0] rdata_o;
  logic        rdata_we_o;
  logic        done_valid_o, done_ready_i, err_o;

  int n_pass = 0;
  int n_total = 0;
  int we_cnt = 0;

  lsu_axi_master dut (
    .clock(clock), .reset(reset),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_write_i(req_write_i), .req_addr_i(req_addr_i),
    .req_size_i(req_size_i), .req_wdata_i(req_wdata_i),
    .req_wstrb_i(req_wstrb_i),
    .awvalid_o(awvalid_o), .awready_i(awready_i),
    .awaddr_o(awaddr_o), .awid_o(awid_o), .awlen_o(awlen_o),
    .awsize_o(awsize_o), .awburst_o(awburst_o),
    .wvalid_o(wvalid_o), .wready_i(wready_i),
    .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wlast_o(wlast_o),
    .bvalid_i(bvalid_i), .bready_o(bready_o), .bresp_i(bresp_i),
    .arvalid_o(arvalid_o), .arready_i(arready_i),
    .araddr_o(araddr_o), .arid_o(arid_o), .arlen_o(arlen_o),
    .arsize_o(arsize_o), .arburst_o(arburst_o),
    .rvalid_i(rvalid_i), .rready_o(rready_o),
    .rdata_i(rdata_i), .rresp_i(rresp_i), .rlast_i(rlast_i),
    .rdata_o(rdata_o), .rdata_we_o(rdata_we_o),
    .done_valid_o(done_valid_o), .done_ready_i(done_ready_i),
    .err_o(err_o)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (rdata_we_o === 1'b1) we_cnt <= we_cnt + 1;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic do_accept(input logic        wr,
                           input logic [31:0] addr,
                           input logic [2:0]  size,
                           input logic [63:0] wd,
                           input logic [7:0]  ws);
    req_write_i = wr;
    req_addr_i  = addr;
    req_size_i  = size;
    req_wdata_i = wd;
    req_wstrb_i = ws;
    req_valid_i = 1'b1;
    tick();
    req_valid_i = 1'b0;
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_reqrdy"}, req_ready_o, 1'b1);
    chk({tag, "_arv"}, arvalid_o, 1'b0);
    chk({tag, "_rrdy"}, rready_o, 1'b0);
    chk({tag, "_awv"}, awvalid_o, 1'b0);
    chk({tag, "_wv"}, wvalid_o, 1'b0);
    chk({tag, "_brdy"}, bready_o, 1'b0);
    chk({tag, "_done"}, done_valid_o, 1'b0);
    chk({tag, "_rdata"}, rdata_o, 64'd0);
    chk({tag, "_err"}, err_o, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    req_valid_i = 0; req_write_i = 0; req_addr_i = 0;
    req_size_i = 0; req_wdata_i = 0; req_wstrb_i = 0;
    awready_i = 0; wready_i = 0; bvalid_i = 0; bresp_i = 0;
    arready_i = 0; rvalid_i = 0; rdata_i = 0; rresp_i = 0;
    rlast_i = 0; done_ready_i = 0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk_idle_outs("rst");
    chk("rst_we", rdata_we_o, 1'b0);

    // Load, zero-wait slave
    do_accept(0, 32'h8000_0008, 3'd2, 64'd0, 8'd0);
    chk("l1_arv", arvalid_o, 1'b1);
    chk("l1_araddr", araddr_o, 32'h8000_0008);
    chk("l1_arsize", arsize_o, 3'd2);
    chk("l1_arlen", arlen_o, 8'd0);
    chk("l1_arburst", arburst_o, 2'b01);
    chk("l1_arid", arid_o, 4'd0);
    chk("l1_reqrdy", req_ready_o, 1'b0);
    arready_i = 1;
    tick();
    arready_i = 0;
    chk("l1_arv_drop", arvalid_o, 1'b0);
    chk("l1_rrdy", rready_o, 1'b1);
    rvalid_i = 1; rdata_i = 64'h1122_3344_5566_7788; rlast_i = 1;
    tick();
    rvalid_i = 0; rlast_i = 0;
    chk("l1_we", rdata_we_o, 1'b1);
    chk("l1_rdata", rdata_o, 64'h1122_3344_5566_7788);
    chk("l1_done", done_valid_o, 1'b1);
    chk("l1_err", err_o, 1'b0);
    chk("l1_rrdy_drop", rready_o, 1'b0);
    done_ready_i = 1;
    tick();
    done_ready_i = 0;
    chk("l1_we_off", rdata_we_o, 1'b0);
    chk("l1_done_off", done_valid_o, 1'b0);
    chk("l1_reqrdy_back", req_ready_o, 1'b1);

    // Load with stalls; request inputs change but are ignored
    do_accept(0, 32'h8000_0100, 3'd3, 64'd0, 8'd0);
    req_addr_i = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      chk("l2_arv_hold", arvalid_o, 1'b1);
      chk("l2_araddr_hold", araddr_o, 32'h8000_0100);
      tick();
    end
    arready_i = 1;
    chk("l2_arv_at_hs", arvalid_o, 1'b1);
    tick();
    arready_i = 0;
    chk("l2_rrdy", rready_o, 1'b1);
    chk("l2_arv_drop", arvalid_o, 1'b0);
    for (int i = 0; i < 2; i++) begin
      chk("l2_rrdy_hold", rready_o, 1'b1);
      chk("l2_we_quiet", rdata_we_o, 1'b0);
      chk("l2_reqrdy", req_ready_o, 1'b0);
      tick();
    end
    rvalid_i = 1; rdata_i = 64'hA5A5_0000_FFFF_1234; rresp_i = 2'b00;
    tick();
    rvalid_i = 0;
    chk("l2_we", rdata_we_o, 1'b1);
    chk("l2_rdata", rdata_o, 64'hA5A5_0000_FFFF_1234);
    chk("l2_done", done_valid_o, 1'b1);
    tick();
    chk("l2_we_once", rdata_we_o, 1'b0);
    chk("l2_done_hold", done_valid_o, 1'b1);
    chk("l2_reqrdy_wait", req_ready_o, 1'b0);
    done_ready_i = 1;
    tick();
    done_ready_i = 0;
    chk("l2_reqrdy_back", req_ready_o, 1'b1);
    chk("l2_we_cnt", 64'(we_cnt), 64'd2);

    // Store, W before AW, SLVERR; stray R beats ignored
    do_accept(1, 32'h0000_1000, 3'd3, 64'hCAFE_F00D_1234_5678, 8'hFF);
    chk("s1_awv", awvalid_o, 1'b1);
    chk("s1_wv", wvalid_o, 1'b1);
    chk("s1_awaddr", awaddr_o, 32'h0000_1000);
    chk("s1_wdata", wdata_o, 64'hCAFE_F00D_1234_5678);
    wready_i = 1;
    rvalid_i = 1; rdata_i = 64'hBAD0_BAD0_BAD0_BAD0;
    tick();
    wready_i = 0;
    chk("s1_wv_drop", wvalid_o, 1'b0);
    chk("s1_awv_hold", awvalid_o, 1'b1);
    chk("s1_brdy_early", bready_o, 1'b0);
    tick();
    chk("s1_awv_c3", awvalid_o, 1'b1);
    tick();
    awready_i = 1;
    tick();
    awready_i = 0;
    chk("s1_awv_drop", awvalid_o, 1'b0);
    chk("s1_brdy", bready_o, 1'b1);
    bvalid_i = 1; bresp_i = 2'b10;
    tick();
    bvalid_i = 0; bresp_i = 2'b00; rvalid_i = 0;
    chk("s1_done", done_valid_o, 1'b1);
    chk("s1_err", err_o, 1'b1);
    chk("s1_brdy_drop", bready_o, 1'b0);
    chk("s1_rdata_keep", rdata_o, 64'hA5A5_0000_FFFF_1234);
    chk("s1_we_cnt", 64'(we_cnt), 64'd2);
    done_ready_i = 1;
    tick();
    done_ready_i = 0;

    // Stray readies/responses in IDLE are ignored
    awready_i = 1; wready_i = 1; bvalid_i = 1; arready_i = 1;
    tick();
    awready_i = 0; wready_i = 0; bvalid_i = 0; arready_i = 0;
    chk("idle_reqrdy", req_ready_o, 1'b1);
    chk("idle_brdy", bready_o, 1'b0);
    chk("idle_done", done_valid_o, 1'b0);

    // Store, AW and W together, EXOKAY response
    do_accept(1, 32'h0000_2008, 3'd3, 64'h0000_0000_DEAD_BEEF, 8'h0F);
    chk("s2_wlast", wlast_o, 1'b1);
    chk("s2_awlen", awlen_o, 8'd0);
    chk("s2_awburst", awburst_o, 2'b01);
    chk("s2_awsize", awsize_o, 3'd3);
    chk("s2_awid", awid_o, 4'd0);
    chk("s2_wstrb", wstrb_o, 8'h0F);
    chk("s2_wdata", wdata_o, 64'h0000_0000_DEAD_BEEF);
    awready_i = 1; wready_i = 1;
    tick();
    awready_i = 0; wready_i = 0;
    chk("s2_awv_drop", awvalid_o, 1'b0);
    chk("s2_wv_drop", wvalid_o, 1'b0);
    chk("s2_brdy", bready_o, 1'b1);
    bvalid_i = 1; bresp_i = 2'b01;
    tick();
    bvalid_i = 0; bresp_i = 2'b00;
    chk("s2_done", done_valid_o, 1'b1);
    chk("s2_err", err_o, 1'b1);

    // Backpressure on done with a pending load request
    req_write_i = 0; req_addr_i = 32'h2000_0040;
    req_size_i = 3'd3; req_valid_i = 1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_done_hold", done_valid_o, 1'b1);
      chk("bp_err_hold", err_o, 1'b1);
      chk("bp_reqrdy", req_ready_o, 1'b0);
      chk("bp_arv", arvalid_o, 1'b0);
      tick();
    end
    done_ready_i = 1;
    tick();
    done_ready_i = 0;
    chk("bp_reqrdy_back", req_ready_o, 1'b1);
    chk("bp_done_off", done_valid_o, 1'b0);
    chk("bp_no_accept", arvalid_o, 1'b0);
    tick();
    req_valid_i = 0;
    chk("bp_arv", arvalid_o, 1'b1);
    chk("bp_araddr", araddr_o, 32'h2000_0040);
    chk("bp_reqrdy_low", req_ready_o, 1'b0);
    arready_i = 1;
    tick();
    arready_i = 0;
    chk("bp_rrdy", rready_o, 1'b1);

    // Asynchronous reset while waiting in RDATA
    reset = 1'b1;
    #1;
    chk_idle_outs("arst");
    tick();
    reset = 1'b0;
    tick();

    // Fresh load after reset
    do_accept(0, 32'h3000_0000, 3'd2, 64'd0, 8'd0);
    chk("l3_arv", arvalid_o, 1'b1);
    chk("l3_araddr", araddr_o, 32'h3000_0000);
    arready_i = 1;
    tick();
    arready_i = 0;
    rvalid_i = 1; rdata_i = 64'h0123_4567_89AB_CDEF; rresp_i = 2'b00;
    tick();
    rvalid_i = 0;
    chk("l3_we", rdata_we_o, 1'b1);
    chk("l3_rdata", rdata_o, 64'h0123_4567_89AB_CDEF);
    chk("l3_done", done_valid_o, 1'b1);
    chk("l3_err", err_o, 1'b0);
    done_ready_i = 1;
    tick();
    done_ready_i = 0;
    chk("l3_reqrdy", req_ready_o, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
